// File: rtl/aes_adapt_pkg.sv
// Shared state encoding, block geometry and byte-select helper for the AES byte-stream adapter.
// Also imported by the collector so that BIST reuse sees the same byte ordering.
package aes_adapt_pkg;

  localparam int AES_BLK_BYTES = 16;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_BLK_W     = AES_BLK_BYTES * AES_BYTE_W;

  typedef enum logic [2:0] {IDLE, CRST, LOAD, WAIT, COLLECT, DONE} adapt_state_e;

  // Byte i of a block, byte 0 being the most significant.
  function automatic logic [AES_BYTE_W-1:0] byte_at(input logic [AES_BLK_W-1:0] w,
                                                    input logic [3:0]           i);
    logic [AES_BLK_W-1:0] t;
    t = w << {i, 3'b000};
    return t[AES_BLK_W-1 -: AES_BYTE_W];
  endfunction

endpackage

// File: rtl/aes_byte_collector.sv
// Shifts qualified bytes into a 128-bit word, first byte ending up MSB; one byte per enabled cycle.
// Saturates after 16 bytes: further enables are ignored until clr.
module aes_byte_collector
  import aes_adapt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [AES_BYTE_W-1:0] din,
  output logic [AES_BLK_W-1:0]  sh,
  output logic [3:0]            cnt
);

  logic full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      sh   <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (en && !full) begin
      sh  <= {sh[AES_BLK_W-AES_BYTE_W-1:0], din};
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) full <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_byte_stream_adapter.sv
// Serialises key/plaintext to the 8-bit AES core and reassembles its ciphertext; first byte 1+RST_CYCLES after start.
// No backpressure: start is dropped unless idle; AES_ADAPT_WATCHDOG_EN bounds the wait for ciphertext.
module aes_byte_stream_adapter
  import aes_adapt_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [AES_BLK_W-1:0]  key,
  input  logic [AES_BLK_W-1:0]  ptext,
  output logic                  busy,
  output logic [AES_BLK_W-1:0]  ctext,
  output logic                  ctext_vld,
  output logic                  err,
  output logic                  aes_rst,
  output logic [AES_BYTE_W-1:0] aes_key_in,
  output logic [AES_BYTE_W-1:0] aes_din,
  input  logic [AES_BYTE_W-1:0] aes_dout,
  input  logic                  aes_valid,
  input  logic                  aes_done
);

  adapt_state_e         state;
  logic [AES_BLK_W-1:0] key_sh;
  logic [AES_BLK_W-1:0] ptext_sh;
  logic [3:0]           idx;
  logic [31:0]          rst_cnt;
  logic                 col_en;
  logic [AES_BLK_W-1:0] col_sh;
  logic [3:0]           col_cnt;
  logic                 wd_fire;

  assign col_en = aes_valid && (state == WAIT || state == COLLECT);

  aes_byte_collector u_col (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (state == IDLE),
    .en    (col_en),
    .din   (aes_dout),
    .sh    (col_sh),
    .cnt   (col_cnt)
  );

`ifdef AES_ADAPT_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        unused_ok;

  assign unused_ok = aes_done;
  assign wd_fire   = (state == WAIT || state == COLLECT) && (wd_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= wd_fire && !abort;
      if (state == WAIT || state == COLLECT) wd_cnt <= wd_cnt + 32'd1;
      else                                   wd_cnt <= '0;
    end
  end
`else
  logic unused_ok;

  // Completion is byte-count based, so aes_done is status only.
  assign unused_ok = aes_done ^ (TIMEOUT_CYCLES == 0);
  assign wd_fire   = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      ctext      <= '0;
      ctext_vld  <= 1'b0;
      aes_rst    <= 1'b1;
      aes_key_in <= '0;
      aes_din    <= '0;
      key_sh     <= '0;
      ptext_sh   <= '0;
      idx        <= '0;
      rst_cnt    <= '0;
    end else begin
      ctext_vld <= 1'b0;
      if (state != IDLE && (abort || wd_fire)) begin
        // Cancelled runs leave ctext untouched and give the core a one-cycle reset.
        state      <= IDLE;
        busy       <= 1'b0;
        aes_rst    <= 1'b1;
        aes_key_in <= '0;
        aes_din    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              key_sh   <= key;
              ptext_sh <= ptext;
              busy     <= 1'b1;
              aes_rst  <= 1'b1;
              rst_cnt  <= '0;
              state    <= CRST;
            end else begin
              aes_rst <= 1'b0;
            end
          end
          CRST: begin
            if (rst_cnt == RST_CYCLES - 1) begin
              aes_rst    <= 1'b0;
              aes_key_in <= byte_at(key_sh, 4'd0);
              aes_din    <= byte_at(ptext_sh, 4'd0);
              idx        <= '0;
              state      <= LOAD;
            end else begin
              rst_cnt <= rst_cnt + 32'd1;
            end
          end
          LOAD: begin
            if (idx == 4'd15) begin
              aes_key_in <= '0;
              aes_din    <= '0;
              state      <= WAIT;
            end else begin
              idx        <= idx + 4'd1;
              aes_key_in <= byte_at(key_sh, idx + 4'd1);
              aes_din    <= byte_at(ptext_sh, idx + 4'd1);
            end
          end
          WAIT: begin
            if (aes_valid) state <= COLLECT;
          end
          COLLECT: begin
            if (aes_valid && col_cnt == 4'd15) state <= DONE;
          end
          DONE: begin
            ctext     <= col_sh;
            ctext_vld <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_stream_adapter.sv
// Directed bench for aes_byte_stream_adapter: timeline/queue reference model plus literal known answers.
module tb_aes_byte_stream_adapter;

  localparam int R = 2;
  localparam int T = 64;
  localparam int WAIT0 = R + 17;
`ifdef AES_ADAPT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ptext = '0;
  logic         busy;
  logic [127:0] ctext;
  logic         ctext_vld;
  logic         err;
  logic         aes_rst;
  logic [7:0]   aes_key_in;
  logic [7:0]   aes_din;
  logic [7:0]   aes_dout = '0;
  logic         aes_valid = 1'b0;
  logic         aes_done = 1'b0;

  aes_byte_stream_adapter #(.RST_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort), .key(key), .ptext(ptext),
    .busy(busy), .ctext(ctext), .ctext_vld(ctext_vld), .err(err), .aes_rst(aes_rst),
    .aes_key_in(aes_key_in), .aes_din(aes_din), .aes_dout(aes_dout), .aes_valid(aes_valid),
    .aes_done(aes_done)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: ingress is a timeline measured from the accepted start, egress a byte queue.
  bit           m_busy = 1'b0;
  bit           m_fin = 1'b0;
  int           m_t = 0;
  logic [127:0] m_k = '0;
  logic [127:0] m_p = '0;
  logic [7:0]   m_q[$];
  logic [127:0] m_ctext = '0;
  logic         m_vld = 1'b0;
  logic         m_err = 1'b0;
  logic         m_rst = 1'b1;
  logic [7:0]   m_key = '0;
  logic [7:0]   m_din = '0;

  always begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) begin
      m_busy = 1'b0; m_fin = 1'b0; m_t = 0; m_q.delete(); m_ctext = '0;
      m_vld = 1'b0; m_err = 1'b0; m_rst = 1'b1; m_key = '0; m_din = '0;
    end else begin
      m_vld = 1'b0; m_err = 1'b0; m_key = '0; m_din = '0;
      if (m_busy && abort) begin
        m_busy = 1'b0; m_fin = 1'b0; m_rst = 1'b1;
      end else if (WD && m_busy && !m_fin && m_t >= WAIT0 && (m_t - WAIT0) == T - 1) begin
        m_busy = 1'b0; m_rst = 1'b1; m_err = 1'b1;
      end else if (m_fin) begin
        for (int i = 0; i < 16; i++) m_ctext = {m_ctext[119:0], m_q[i]};
        m_vld = 1'b1; m_busy = 1'b0; m_fin = 1'b0; m_rst = 1'b0;
      end else if (m_busy) begin
        if (m_t >= WAIT0 && aes_valid && m_q.size() < 16) begin
          m_q.push_back(aes_dout);
          if (m_q.size() == 16) m_fin = 1'b1;
        end
        m_t++;
        m_rst = (m_t <= R);
        if (m_t > R && m_t <= R + 16) begin
          m_key = m_k[127 - 8*(m_t - R - 1) -: 8];
          m_din = m_p[127 - 8*(m_t - R - 1) -: 8];
        end
      end else begin
        m_rst = 1'b0;
        if (start && !abort) begin
          m_busy = 1'b1; m_t = 1; m_k = key; m_p = ptext; m_q.delete(); m_rst = 1'b1;
        end
      end
    end
  end

  always begin
    @(negedge HCLK);
    if (ctext_vld === 1'b1) vld_cnt++;
    if (err === 1'b1) err_cnt++;
    if (cmp_en) begin
      chk("cyc_busy", 128'(busy), 128'(m_busy));
      chk("cyc_ctext", ctext, m_ctext);
      chk("cyc_ctext_vld", 128'(ctext_vld), 128'(m_vld));
      chk("cyc_err", 128'(err), 128'(m_err));
      chk("cyc_aes_rst", 128'(aes_rst), 128'(m_rst));
      chk("cyc_aes_key_in", 128'(aes_key_in), 128'(m_key));
      chk("cyc_aes_din", 128'(aes_din), 128'(m_din));
    end
  end

  task automatic do_start(input logic [127:0] k, input logic [127:0] p);
    key = k; ptext = p; start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
  endtask

  // Entered in cycle 1 after the accepting edge; returns in the first WAIT cycle.
  task automatic to_wait(input bit chk_in, input bit junk);
    for (int c = 1; c <= R + 16; c++) begin
      if (chk_in) begin
        chk("ingress_rst", 128'(aes_rst), (c <= R) ? 128'd1 : 128'd0);
        if (c > R) begin
          chk("ingress_key", 128'(aes_key_in), 128'(c - R - 1));
          chk("ingress_din", 128'(aes_din), 128'((c - R - 1) * 17));
        end
      end
      aes_valid = junk; aes_dout = 8'hEE;
      @(negedge HCLK);
    end
    aes_valid = 1'b0;
  endtask

  task automatic feed(input logic [127:0] ct, input bit gap);
    logic [127:0] s;
    s = ct;
    for (int i = 0; i < 16; i++) begin
      aes_valid = 1'b1; aes_dout = s[127:120]; s = s << 8;
      @(negedge HCLK);
      if (gap) begin
        aes_valid = 1'b0; aes_dout = 8'h00;
        @(negedge HCLK);
      end
    end
    aes_valid = 1'b1; aes_dout = 8'h5A;
    @(negedge HCLK);
    aes_valid = 1'b0;
  endtask

  task automatic wait_result(input int snap, input logic [127:0] exp, input string name);
    int n;
    n = 0;
    while (vld_cnt == snap && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    repeat (3) @(negedge HCLK);
    chk({name, "_vld_pulses"}, 128'(vld_cnt - snap), 128'd1);
    chk({name, "_ctext"}, ctext, exp);
    chk({name, "_busy"}, 128'(busy), 128'd0);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3 = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

  initial begin
    int snap;
    @(negedge HCLK);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ctext", ctext, 128'd0);
    chk("rst_vld", 128'(ctext_vld), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_aes_rst", 128'(aes_rst), 128'd1);
    chk("rst_key_in", 128'(aes_key_in), 128'd0);
    chk("rst_din", 128'(aes_din), 128'd0);
    HRESETn = 1'b1;
    cmp_en = 1'b1;
    @(negedge HCLK);
    chk("idle_aes_rst", 128'(aes_rst), 128'd0);

    // FIPS-197 C.1 with ingress order checks, stray valids during LOAD and a trailing byte.
    snap = vld_cnt;
    do_start(K1, P1);
    to_wait(1'b1, 1'b1);
    feed(C1, 1'b0);
    wait_result(snap, C1, "fips");

    // Gapped egress.
    snap = vld_cnt;
    do_start(128'hdeadbeef_00000000_11111111_22222222, 128'h5);
    to_wait(1'b0, 1'b0);
    feed(C3, 1'b1);
    wait_result(snap, C3, "gapped");

    // Abort while byte 7 is on the bus, then a clean rerun.
    snap = vld_cnt;
    do_start(K1, P1);
    repeat (R + 7) @(negedge HCLK);
    chk("abort_at_byte7", 128'(aes_key_in), 128'h07);
    abort = 1'b1;
    @(negedge HCLK);
    abort = 1'b0;
    chk("abort_aes_rst", 128'(aes_rst), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    @(negedge HCLK);
    chk("abort_rst_release", 128'(aes_rst), 128'd0);
    repeat (3) @(negedge HCLK);
    chk("abort_ctext_kept", ctext, C3);
    chk("abort_no_vld", 128'(vld_cnt - snap), 128'd0);
    snap = vld_cnt;
    do_start(K1, P1);
    to_wait(1'b0, 1'b0);
    feed(C1, 1'b0);
    wait_result(snap, C1, "rerun");

    // start while busy is dropped.
    snap = vld_cnt;
    do_start(K1, P1);
    start = 1'b1; key = '1;
    @(negedge HCLK);
    start = 1'b0;
    chk("busy_start_ignored", 128'(busy), 128'd1);
    repeat (R + 15) @(negedge HCLK);
    feed(C3, 1'b0);
    wait_result(snap, C3, "busy_start");

    // start together with abort in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge HCLK);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 128'(busy), 128'd0);
    chk("start_abort_rst", 128'(aes_rst), 128'd0);
    @(negedge HCLK);

    // Asynchronous reset in the middle of COLLECT.
    do_start(K1, P1);
    to_wait(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      aes_valid = 1'b1; aes_dout = 8'(8'h30 + i);
      @(negedge HCLK);
    end
    aes_valid = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_ctext", ctext, 128'd0);
    chk("arst_vld", 128'(ctext_vld), 128'd0);
    chk("arst_aes_rst", 128'(aes_rst), 128'd1);
    chk("arst_key_in", 128'(aes_key_in), 128'd0);
    chk("arst_din", 128'(aes_din), 128'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Silent core: watchdog expiry, or an indefinite hang when the watchdog is absent.
    snap = err_cnt;
    do_start(K1, P1);
    to_wait(1'b0, 1'b0);
`ifdef AES_ADAPT_WATCHDOG_EN
    for (int c = 0; c <= T + 3; c++) begin
      chk("wd_err", 128'(err), (c == T) ? 128'd1 : 128'd0);
      chk("wd_aes_rst", 128'(aes_rst), (c == T) ? 128'd1 : 128'd0);
      chk("wd_busy", 128'(busy), (c < T) ? 128'd1 : 128'd0);
      @(negedge HCLK);
    end
    chk("wd_err_pulses", 128'(err_cnt - snap), 128'd1);
    chk("wd_ctext_kept", ctext, 128'd0);
`else
    repeat (10000) @(negedge HCLK);
    chk("hang_err_pulses", 128'(err_cnt - snap), 128'd0);
    chk("hang_busy", 128'(busy), 128'd1);
    abort = 1'b1;
    @(negedge HCLK);
    abort = 1'b0;
    chk("hang_abort_busy", 128'(busy), 128'd0);
    @(negedge HCLK);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
